egress_collector: RTL and testbench
===================================

EGRESS_COLLECTOR -- requirements
Module: egress_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning word width; bits [DATA_W-1:DATA_W-2] are the destination field.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of each per-port word counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port fifo_empty, input, 4, empty flags of egress FIFOs 4..7 (bit i = FIFO 4+i).
REQ-006 SHALL have ports fifo4_out, fifo5_out, fifo6_out and fifo7_out, input, DATA_W each, egress FIFO read data, valid the cycle after pop.
REQ-007 SHALL have port pop, output, 4, one-cycle read strobe per egress FIFO.
REQ-008 SHALL have port out_data, output, DATA_W, the serialized word.
REQ-009 SHALL have port out_src, output, 2, the index of the egress port that supplied out_data.
REQ-010 SHALL have port out_valid, output, 1, out_data/out_src valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accept; a transfer occurs when out_valid && out_ready.
REQ-012 SHALL have port dest_err, output, 1, sticky destination-mismatch flag.
REQ-013 SHALL have port cnt0..cnt3, output, CNT_W each, words delivered per port.

Function
REQ-014 SHALL implement FSM states IDLE, POP, CAPTURE, SEND.
REQ-015 IDLE: if any fifo_empty bit is 0, SHALL grant one port round-robin and go to POP; otherwise stay in IDLE.
REQ-016 Round-robin SHALL search from (last_grant+1) mod 4 upward, wrapping 3->0; after reset last_grant = 3, so port 0 has first priority.
REQ-017 POP: SHALL assert exactly one pop bit (the granted port) for exactly one cycle, then go to CAPTURE.
REQ-018 CAPTURE: SHALL register the granted FIFO's data into out_data and the grant into out_src, then go to SEND.
REQ-019 SEND: SHALL hold out_valid=1 with out_data/out_src stable until out_ready=1.
REQ-020 On the transfer cycle, SHALL increment cnt[out_src] (wrapping modulo 2^CNT_W), update last_grant, and go to IDLE.
REQ-021 Minimum latency SHALL be 3 cycles from grant to out_valid; peak throughput is one word per 4 cycles.
REQ-022 pop SHALL never be asserted for a port whose fifo_empty bit is 1 in that cycle; if the granted port's empty flag rises before POP, the FSM SHALL return to IDLE without popping.
REQ-023 If the captured word's destination field != out_src, SHALL set dest_err=1 (sticky until reset) and still deliver the word.
REQ-024 out_ready asserted outside SEND SHALL be ignored.
REQ-025 Changes on fifo_empty during SEND SHALL not affect the word in flight.

Reset
REQ-026 With reset=1 at a clock edge: state=IDLE, pop=0, out_valid=0, out_data=0, out_src=0, dest_err=0, cnt0..cnt3=0, last_grant=3.
REQ-027 Reset mid-operation SHALL discard any captured word; no pop is issued in the reset cycle or the cycle after it.

Structure
REQ-028 A shared package SHALL hold DATA_W, the destination field bit positions, the FSM state encoding (2 bits) and the number of ports (4).
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter4: inputs req[3:0] and last[1:0]; outputs gnt_idx[1:0] and any.

Verification
REQ-030 Bench SHALL cover reset, then fifo_empty=4'b1110, fifo4_out=10'h0AA, out_ready=1 -> pop=4'b0001 at cycle 1, out_valid at cycle 3 with out_data=10'h0AA, out_src=0, cnt0=1, dest_err=0.
REQ-031 Bench SHALL cover all four FIFOs non-empty continuously -> grants in order 0,1,2,3,0; each pop one cycle wide; words spaced 4 cycles apart.
REQ-032 Bench SHALL cover out_ready held 0 for 10 cycles in SEND -> out_valid held with data stable, no further pop; on out_ready=1 a single transfer occurs.
REQ-033 Bench SHALL cover port 2 supplying word 10'h1FF (dest field 01) -> word delivered with out_src=2, dest_err=1 and remaining 1 after later correct words.
REQ-034 Bench SHALL cover 256 words from port 1 with CNT_W=8 -> cnt1 wraps to 0.
REQ-035 Bench SHALL cover reset asserted during CAPTURE -> out_valid stays 0, counters 0, next grant is port 0.

Source files
------------

// File: rtl/egress_collector_pkg.sv
// Shared constants for the egress collector: word layout, port count and FSM encoding.
package egress_collector_pkg;

    localparam int DATA_W    = 10;
    localparam int DEST_W    = 2;
    localparam int DEST_HI   = DATA_W - 1;
    localparam int DEST_LO   = DATA_W - DEST_W;
    localparam int NUM_PORTS = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_POP     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;

endpackage

// File: rtl/egress_collector_rr_arbiter4.sv
// Four-way round-robin pick: the first requester after 'last', wrapping 3->0.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt_idx,
    output logic       any
);

    assign any = |req;

    // Scan farthest-first so the nearest requester after 'last' overwrites.
    always_comb begin
        gnt_idx = '0;
        for (int k = 4; k >= 1; k--) begin
            if (req[last + 2'(k)]) begin
                gnt_idx = last + 2'(k);
            end
        end
    end

endmodule

// File: rtl/egress_collector.sv
// Collects words from egress FIFOs 4..7 round-robin and serialises them onto a
// valid/ready output, counting words per port and flagging destination mismatches.
//
// state      | meaning
// IDLE       | waiting for any non-empty FIFO, grants one port
// POP        | one-cycle read strobe to the granted FIFO
// CAPTURE    | FIFO read data registered into out_data/out_src
// SEND       | out_valid held until out_ready
module egress_collector #(
    parameter int DATA_W = egress_collector_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        fifo_empty,
    input  logic [DATA_W-1:0] fifo4_out,
    input  logic [DATA_W-1:0] fifo5_out,
    input  logic [DATA_W-1:0] fifo6_out,
    input  logic [DATA_W-1:0] fifo7_out,
    output logic [3:0]        pop,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              dest_err,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
);
    import egress_collector_pkg::*;

    logic [1:0]        state;
    logic [1:0]        grant;
    logic [1:0]        last_grant;
    logic [1:0]        gnt_idx;
    logic              any_req;
    logic [DATA_W-1:0] fifo_sel;
    logic [CNT_W-1:0]  cnt [NUM_PORTS];

    rr_arbiter4 u_arb (
        .req     (~fifo_empty),
        .last    (last_grant),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    always_comb begin
        fifo_sel = '0;
        case (grant)
            2'd0: fifo_sel = fifo4_out;
            2'd1: fifo_sel = fifo5_out;
            2'd2: fifo_sel = fifo6_out;
            2'd3: fifo_sel = fifo7_out;
            default: fifo_sel = '0;
        endcase
    end

    // The empty flag is re-checked here so a FIFO drained after grant is never popped.
    always_comb begin
        pop = '0;
        if (state == ST_POP && !reset && !fifo_empty[grant]) begin
            pop[grant] = 1'b1;
        end
    end

    assign out_valid = (state == ST_SEND);
    assign cnt0      = cnt[0];
    assign cnt1      = cnt[1];
    assign cnt2      = cnt[2];
    assign cnt3      = cnt[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;
            out_data   <= '0;
            out_src    <= 2'd0;
            dest_err   <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant <= gnt_idx;
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    state <= fifo_empty[grant] ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    out_data <= fifo_sel;
                    out_src  <= grant;
                    if (fifo_sel[DATA_W-1 -: DEST_W] != grant) begin
                        dest_err <= 1'b1;
                    end
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        cnt[out_src] <= cnt[out_src] + 1'b1;
                        last_grant   <= out_src;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_egress_collector.sv
// Self-checking bench for egress_collector: queue-backed FIFO models and a
// transaction-level round-robin reference.
module tb_egress_collector;

    localparam int DW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    fifo_empty = 4'hF;
    logic [DW-1:0] fout [4];
    logic [3:0]    pop;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          dest_err;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DW-1:0] q [4][$];
    logic [DW-1:0] got_d [$];
    logic [1:0]    got_s [$];
    int            got_c [$];
    logic [DW-1:0] exp_d [$];
    logic [1:0]    exp_s [$];

    egress_collector #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo4_out  (fout[0]),
        .fifo5_out  (fout[1]),
        .fifo6_out  (fout[2]),
        .fifo7_out  (fout[3]),
        .pop        (pop),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dest_err   (dest_err),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt3       (cnt3)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW-1:0] cnt_of(input int p);
        case (p)
            0: return cnt0;
            1: return cnt1;
            2: return cnt2;
            default: return cnt3;
        endcase
    endfunction

    task automatic refresh();
        for (int i = 0; i < 4; i++) fifo_empty[i] = (q[i].size() == 0);
    endtask

    // One clock: FIFO models react to the pop seen before the edge; data valid next cycle.
    task automatic tick();
        logic [3:0] p_now;
        p_now = pop;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (p_now[i] && q[i].size() > 0) fout[i] = q[i].pop_front();
        end
        refresh();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        got_d.delete(); got_s.delete(); got_c.delete();
        refresh();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Transaction-level reference: serve non-empty queues round-robin, port 0 first.
    task automatic build_model();
        logic [DW-1:0] cp [4][$];
        int last;
        bit found;
        exp_d.delete(); exp_s.delete();
        for (int i = 0; i < 4; i++) cp[i] = q[i];
        last = 3;
        do begin
            found = 0;
            for (int k = 1; k <= 4 && !found; k++) begin
                int p;
                p = (last + k) % 4;
                if (cp[p].size() > 0) begin
                    exp_d.push_back(cp[p].pop_front());
                    exp_s.push_back(2'(p));
                    last = p;
                    found = 1;
                end
            end
        end while (found);
    endtask

    task automatic run(input int n_words, input int budget, input bit rnd);
        int start;
        start = got_d.size();
        for (int c = 0; c < budget && (got_d.size() - start) < n_words; c++) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            checks++;
            if ($countones(pop) > 1 || (pop & fifo_empty) != 4'b0) begin
                errors++;
                $display("FAIL pop_legal: pop=%b empty=%b at cycle %0d", pop, fifo_empty, cyc);
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_s.push_back(out_src);
                got_c.push_back(cyc);
            end
            tick();
        end
        checks++;
        if ((got_d.size() - start) != n_words) begin
            errors++;
            $display("FAIL run_timeout: got %0d words, expected %0d", got_d.size() - start, n_words);
        end
    endtask

    task automatic compare_model(input string tag);
        for (int k = 0; k < exp_d.size(); k++) begin
            checks++;
            if (k >= got_d.size()) begin
                errors++;
                $display("FAIL %s word%0d: missing, expected data=%h src=%0d", tag, k, exp_d[k], exp_s[k]);
            end else if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k]) begin
                errors++;
                $display("FAIL %s word%0d: got data=%h src=%0d, expected data=%h src=%0d",
                         tag, k, got_d[k], got_s[k], exp_d[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        q[0].push_back(10'h155);
        refresh();
        reset = 1'b1;
        tick();
        checks += 6;
        if (pop !== 4'b0)    begin errors++; $display("FAIL rst_pop: got %b expected 0000", pop); end
        if (out_valid !== 0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 000", out_data); end
        if (out_src !== 2'd0) begin errors++; $display("FAIL rst_src: got %0d expected 0", out_src); end
        if (dest_err !== 0)  begin errors++; $display("FAIL rst_dest_err: got %b expected 0", dest_err); end
        if ({cnt0, cnt1, cnt2, cnt3} !== '0) begin
            errors++; $display("FAIL rst_cnt: got %h %h %h %h expected 0", cnt0, cnt1, cnt2, cnt3);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_word();
        do_reset();
        q[0].push_back(10'h0AA);
        refresh();
        out_ready = 1'b1;
        tick();
        checks++;
        if (pop !== 4'b0001) begin errors++; $display("FAIL first_pop: got %b expected 0001", pop); end
        tick();
        checks++;
        if (out_valid !== 0 || pop !== 4'b0) begin
            errors++; $display("FAIL first_c2: valid=%b pop=%b expected 0/0000", out_valid, pop);
        end
        tick();
        checks += 3;
        if (out_valid !== 1) begin errors++; $display("FAIL first_valid: got %b expected 1", out_valid); end
        if (out_data !== 10'h0AA || out_src !== 2'd0) begin
            errors++; $display("FAIL first_word: got %h/%0d expected 0aa/0", out_data, out_src);
        end
        if (dest_err !== 0) begin errors++; $display("FAIL first_dest_err: got %b expected 0", dest_err); end
        tick();
        checks++;
        if (cnt0 !== 8'd1 || out_valid !== 0) begin
            errors++; $display("FAIL first_cnt0: cnt0=%0d valid=%b expected 1/0", cnt0, out_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++) q[p].push_back({2'(p), 8'($urandom)});
        refresh();
        build_model();
        out_ready = 1'b1;
        run(8, 100, 0);
        compare_model("rr");
        for (int k = 0; k < got_s.size(); k++) begin
            checks++;
            if (got_s[k] !== 2'(k % 4)) begin
                errors++; $display("FAIL rr_order%0d: got port %0d expected %0d", k, got_s[k], k % 4);
            end
            if (k > 0) begin
                checks++;
                if (got_c[k] - got_c[k-1] != 4) begin
                    errors++; $display("FAIL rr_spacing%0d: got %0d cycles expected 4", k, got_c[k] - got_c[k-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d0;
        int n;
        do_reset();
        q[1].push_back({2'd1, 8'h3C});
        q[2].push_back({2'd2, 8'h5A});
        refresh();
        n = 0;
        while (!out_valid && n < 10) begin tick(); n++; end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL stall_reach: out_valid=%b expected 1", out_valid); end
        d0 = out_data;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1 || out_data !== {2'd1, 8'h3C} || out_src !== 2'd1 || pop !== 4'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b data=%h src=%0d pop=%b expected 1/13c/1/0000",
                         c, out_valid, out_data, out_src, pop);
            end
            tick();
        end
        checks++;
        if (out_data !== d0) begin errors++; $display("FAIL stall_stable: got %h expected %h", out_data, d0); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (cnt1 !== 8'd1 || out_valid !== 0) begin
            errors++; $display("FAIL stall_xfer: cnt1=%0d valid=%b expected 1/0", cnt1, out_valid);
        end
        tick(); tick(); tick();
        checks++;
        if (out_valid !== 1 || out_src !== 2'd2 || out_data !== {2'd2, 8'h5A}) begin
            errors++; $display("FAIL stall_next: valid=%b src=%0d data=%h expected 1/2/25a", out_valid, out_src, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (cnt1 !== 8'd1 || cnt2 !== 8'd1) begin
            errors++; $display("FAIL stall_counts: cnt1=%0d cnt2=%0d expected 1/1", cnt1, cnt2);
        end
    endtask

    task automatic test_dest_err();
        do_reset();
        q[2].push_back(10'h1FF);
        refresh();
        out_ready = 1'b1;
        run(1, 20, 0);
        checks++;
        if (got_d.size() != 1 || got_d[0] !== 10'h1FF || got_s[0] !== 2'd2 || dest_err !== 1) begin
            errors++; $display("FAIL dest_err_set: words=%0d dest_err=%b expected 1 word 1ff from 2, dest_err=1",
                               got_d.size(), dest_err);
        end
        q[0].push_back({2'd0, 8'h11});
        q[3].push_back({2'd3, 8'h22});
        refresh();
        run(2, 60, 1);
        checks += 2;
        if (got_s.size() != 3 || got_s[1] !== 2'd3 || got_s[2] !== 2'd0) begin
            errors++; $display("FAIL dest_err_order: got %0d words, expected ports 3 then 0", got_s.size());
        end
        if (dest_err !== 1 || cnt0 !== 8'd1 || cnt2 !== 8'd1 || cnt3 !== 8'd1) begin
            errors++; $display("FAIL dest_err_sticky: dest_err=%b cnt0=%0d cnt2=%0d cnt3=%0d expected 1/1/1/1",
                               dest_err, cnt0, cnt2, cnt3);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 256; k++) q[1].push_back({2'd1, 8'(k)});
        refresh();
        out_ready = 1'b1;
        run(255, 255 * 4 + 20, 0);
        checks++;
        if (cnt1 !== 8'd255) begin errors++; $display("FAIL wrap_255: cnt1=%0d expected 255", cnt1); end
        run(1, 20, 0);
        checks += 2;
        if (cnt1 !== 8'd0) begin errors++; $display("FAIL wrap_zero: cnt1=%0d expected 0", cnt1); end
        if (got_d.size() != 256 || got_d[got_d.size()-1] !== {2'd1, 8'hFF}) begin
            errors++; $display("FAIL wrap_last: words=%0d expected 256 ending 1ff", got_d.size());
        end
    endtask

    task automatic test_reset_capture();
        do_reset();
        q[1].push_back({2'd1, 8'h77});
        refresh();
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 0 || pop !== 4'b0 || cnt1 !== 8'd0 || out_data !== '0) begin
            errors++; $display("FAIL rcap_reset: valid=%b pop=%b cnt1=%0d data=%h expected 0", out_valid, pop, cnt1, out_data);
        end
        reset = 1'b0;
        q[0].push_back({2'd0, 8'h44});
        q[1].push_back({2'd1, 8'h55});
        refresh();
        checks++;
        if (pop !== 4'b0 || out_valid !== 0) begin
            errors++; $display("FAIL rcap_after: pop=%b valid=%b expected 0000/0", pop, out_valid);
        end
        build_model();
        run(2, 40, 0);
        compare_model("rcap");
        checks++;
        if (cnt0 !== 8'd1 || cnt1 !== 8'd1 || cnt2 !== 8'd0 || cnt3 !== 8'd0) begin
            errors++; $display("FAIL rcap_counts: %0d %0d %0d %0d expected 1 1 0 0", cnt0, cnt1, cnt2, cnt3);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 6; round++) begin
            int ecnt [4];
            bit ederr;
            do_reset();
            for (int p = 0; p < 4; p++) begin
                int n;
                n = $urandom_range(0, 5);
                for (int k = 0; k < n; k++) q[p].push_back(DW'($urandom));
            end
            refresh();
            build_model();
            run(exp_d.size(), 400, 1);
            compare_model("rand");
            ederr = 0;
            for (int p = 0; p < 4; p++) ecnt[p] = 0;
            for (int k = 0; k < exp_d.size(); k++) begin
                ecnt[exp_s[k]]++;
                if (exp_d[k][DW-1:DW-2] != exp_s[k]) ederr = 1;
            end
            checks++;
            if (dest_err !== ederr) begin
                errors++; $display("FAIL rand_dest_err r%0d: got %b expected %b", round, dest_err, ederr);
            end
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (cnt_of(p) !== CW'(ecnt[p])) begin
                    errors++; $display("FAIL rand_cnt%0d r%0d: got %0d expected %0d", p, round, cnt_of(p), ecnt[p]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) fout[i] = '0;
        test_reset();
        test_first_word();
        test_round_robin();
        test_stall();
        test_dest_err();
        test_wrap();
        test_reset_capture();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
